// File: rtl/trip_eval_if.sv
// trip_eval_if: request/result bundle between the caller and the trip evaluation sequencer.
interface trip_eval_if #(parameter int NChannels = 3, parameter int Log2Modes = 2);
  logic start, clear_overrun, out_ready, out_valid, busy, overrun;
  logic [NChannels*32-1:0] vals, setpoints;
  logic [NChannels*Log2Modes-1:0] modes;
  logic [NChannels-1:0] trips, sensor_trips;
  modport master(output start, vals, setpoints, modes, clear_overrun, out_ready,
                 input out_valid, trips, sensor_trips, busy, overrun);
  modport slave(input start, vals, setpoints, modes, clear_overrun, out_ready,
                output out_valid, trips, sensor_trips, busy, overrun);
endinterface

// File: rtl/trip_eval_sequencer.sv
// trip_eval_sequencer: one shared 32-bit setpoint comparator stepped across channels, mode rule applied,
// result offered over valid/ready.
module trip_eval_sequencer #(
  parameter int NChannels = 3,
  parameter int SignedCh = 2,
  parameter int Log2Modes = 2
) (
  input logic clk,
  input logic rst_n,
  trip_eval_if.slave bus
);
  localparam int IW = NChannels > 1 ? $clog2(NChannels) : 1;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NChannels*32-1:0] vals_q, vals_d, sp_q, sp_d;
  logic [NChannels*Log2Modes-1:0] modes_q, modes_d;
  logic [NChannels-1:0] res_q, res_d, trips_q, trips_d, sens_q, sens_d;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic [31:0] v, sp;
  logic hit, load, drop;
  logic [Log2Modes-1:0] m;
  always_comb begin
    v = vals_q[int'(idx_q)*32 +: 32];
    sp = sp_q[int'(idx_q)*32 +: 32];
    hit = (int'(idx_q) == SignedCh) ? ($signed(v) < $signed(sp)) : (sp > v);
    // a start is only taken when idle or on the same edge the result is accepted
    load = bus.start && (state_q == IDLE || (state_q == DONE && bus.out_ready));
    drop = bus.start && !load;
    overrun_d = drop ? 1'b1 : bus.clear_overrun ? 1'b0 : overrun_q;
    state_d = state_q;
    idx_d = idx_q;
    vals_d = vals_q;
    sp_d = sp_q;
    modes_d = modes_q;
    res_d = res_q;
    trips_d = trips_q;
    sens_d = sens_q;
    out_valid_d = out_valid_q;
    m = '0;
    if (state_q == EVAL) begin
      res_d[idx_q] = hit;
      if (int'(idx_q) == NChannels - 1) begin
        state_d = DONE;
        sens_d = res_d;
        out_valid_d = 1'b1;
        for (int c = 0; c < NChannels; c++) begin
          m = modes_q[c*Log2Modes +: Log2Modes];
          trips_d[c] = (m == Log2Modes'(2)) || ((m == Log2Modes'(1)) && res_d[c]);
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (state_q == DONE && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
    end
    if (load) begin
      vals_d = bus.vals;
      sp_d = bus.setpoints;
      modes_d = bus.modes;
      idx_d = '0;
      state_d = EVAL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      vals_q <= '0;
      sp_q <= '0;
      modes_q <= '0;
      res_q <= '0;
      trips_q <= '0;
      sens_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vals_q <= vals_d;
      sp_q <= sp_d;
      modes_q <= modes_d;
      res_q <= res_d;
      trips_q <= trips_d;
      sens_q <= sens_d;
      out_valid_q <= out_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.trips = trips_q;
  assign bus.sensor_trips = sens_q;
  assign bus.busy = state_q != IDLE;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_trip_eval_sequencer.sv
// tb_trip_eval_sequencer: directed table vectors plus hand sequences for backpressure, back-to-back,
// overrun and mid-pass reset.
module tb_trip_eval_sequencer;
  logic clk, rst_n;
  int total = 0, bad = 0;
  trip_eval_if #(.NChannels(3), .Log2Modes(2)) bus();
  trip_eval_sequencer #(.NChannels(3), .SignedCh(2), .Log2Modes(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic [95:0] vals, sp;
    logic [5:0] modes;
    logic [2:0] sens, trips;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic start_pass(vec_t t);
    @(negedge clk);
    bus.vals = t.vals;
    bus.setpoints = t.sp;
    bus.modes = t.modes;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic wait_done(vec_t t, string nm, int n0);
    int n = n0;
    while (!bus.out_valid && n < 10) begin
      chk({nm, "_busy"}, 32'(bus.busy), 1);
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, 3);
    chk({nm, "_sens"}, 32'(bus.sensor_trips), 32'(t.sens));
    chk({nm, "_trips"}, 32'(bus.trips), 32'(t.trips));
    chk({nm, "_busy_done"}, 32'(bus.busy), 1);
  endtask
  task automatic accept(string nm);
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    chk({nm, "_acc_valid"}, 32'(bus.out_valid), 0);
    chk({nm, "_acc_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    vec_t t;
    int err;
    tbl[0] = '{{32'hFFFFFFF0, 32'd100, 32'd50}, {32'd0, 32'd200, 32'd40}, 6'b010101, 3'b110, 3'b110};
    tbl[1] = '{{3{32'h80000000}}, {3{32'h80000000}}, 6'b010101, 3'b000, 3'b000};
    tbl[2] = '{{32'd5, 32'd100, 32'd50}, {32'd0, 32'd200, 32'd40}, 6'b100011, 3'b010, 3'b100};
    tbl[3] = '{{32'h80000000, 32'hFFFFFFFF, 32'd1}, {32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF}, 6'b010101, 3'b101, 3'b101};
    tbl[4] = '{{32'h80000000, 32'hFFFFFFFF, 32'd1}, {32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF}, 6'b111111, 3'b101, 3'b000};
    tbl[5] = '{{3{32'd7}}, {3{32'd7}}, 6'b101010, 3'b000, 3'b111};
    rst_n = 0;
    bus.start = 1'($urandom);
    bus.vals = {$urandom, $urandom, $urandom};
    bus.setpoints = {$urandom, $urandom, $urandom};
    bus.modes = 6'($urandom);
    bus.clear_overrun = 1'($urandom);
    bus.out_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_trips", 32'(bus.trips), 0);
    chk("rst_sens", 32'(bus.sensor_trips), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    bus.start = 0;
    bus.clear_overrun = 0;
    bus.out_ready = 0;
    rst_n = 1;
    err = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy || bus.trips != 0 || bus.sensor_trips != 0 || bus.overrun) err++;
    end
    chk("idle_after_rst", err, 0);
    for (int i = 0; i < 6; i++) begin
      start_pass(tbl[i]);
      wait_done(tbl[i], $sformatf("vec%0d", i), 0);
      accept($sformatf("vec%0d", i));
    end
    // snapshot isolation and backpressure hold
    start_pass(tbl[0]);
    bus.vals = '0;
    bus.setpoints = '1;
    bus.modes = '0;
    wait_done(tbl[0], "snap", 0);
    err = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid !== 1 || bus.sensor_trips !== tbl[0].sens || bus.trips !== tbl[0].trips) err++;
    end
    chk("hold", err, 0);
    accept("hold");
    // back-to-back: start with the accepting edge
    start_pass(tbl[2]);
    wait_done(tbl[2], "b2b_a", 0);
    bus.vals = tbl[3].vals;
    bus.setpoints = tbl[3].sp;
    bus.modes = tbl[3].modes;
    bus.start = 1;
    bus.out_ready = 1;
    @(negedge clk);
    bus.start = 0;
    bus.out_ready = 0;
    chk("b2b_valid", 32'(bus.out_valid), 0);
    chk("b2b_ovr", 32'(bus.overrun), 0);
    wait_done(tbl[3], "b2b_b", 0);
    chk("b2b_ovr2", 32'(bus.overrun), 0);
    accept("b2b_b");
    // start during EVAL is dropped
    start_pass(tbl[5]);
    bus.start = 1;
    bus.vals = '0;
    @(negedge clk);
    bus.start = 0;
    chk("ovr_set", 32'(bus.overrun), 1);
    wait_done(tbl[5], "ovr", 1);
    bus.clear_overrun = 1;
    @(negedge clk);
    bus.clear_overrun = 0;
    chk("ovr_clr", 32'(bus.overrun), 0);
    bus.start = 1;
    bus.clear_overrun = 1;
    @(negedge clk);
    bus.start = 0;
    bus.clear_overrun = 0;
    chk("ovr_both", 32'(bus.overrun), 1);
    chk("ovr_still_done", 32'(bus.out_valid), 1);
    accept("ovr");
    bus.clear_overrun = 1;
    @(negedge clk);
    bus.clear_overrun = 0;
    chk("ovr_clr2", 32'(bus.overrun), 0);
    // reset in the second EVAL cycle
    start_pass(tbl[0]);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1;
    err = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy || bus.trips != 0 || bus.sensor_trips != 0) err++;
    end
    chk("mid_rst_quiet", err, 0);
    start_pass(tbl[3]);
    wait_done(tbl[3], "post_rst", 0);
    accept("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
